fifo_rd_drain: RTL and testbench

Read-side consumer for the team's 8-bit asynchronous FIFO. Runs entirely in the read clock domain. Pops words with `rd_en`, never while `empty` is high, and absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer. Presents the data downstream as a valid/ready stream with full one-word-per-cycle throughput.

---
 rtl/fifo_rd_drain.sv | 98 +++++++++
 tb/tb_fifo_rd_drain.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drain.sv
// Read-side consumer for the 8-bit async FIFO: pops into a 2-entry skid buffer, streams out valid/ready.
// Optional delivered-word counter enabled by FIFO_RD_DRAIN_COUNT_EN.
module fifo_rd_drain #(
    parameter int unsigned Data_Width = 8,
    parameter int unsigned Cnt_Width  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  drain_en,
    input  logic                  empty,
    input  logic [Data_Width-1:0] data_out,
    output logic                  rd_en,
    output logic                  m_valid,
    output logic [Data_Width-1:0] m_data,
    input  logic                  m_ready,
    output logic [Cnt_Width-1:0]  rd_count,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StRun, StStop} state_t;

    state_t                state;
    logic [1:0]            occ;
    logic                  inflight;
    logic [Data_Width-1:0] buf0;
    logic [Data_Width-1:0] buf1;
    logic                  pop;
    logic [1:0]            occ_next;
    logic                  wr_slot0;

    assign pop      = m_valid && m_ready;
    assign occ_next = occ + {1'b0, inflight} - {1'b0, pop};
    // Counting the in-flight word guarantees its landing slot is free.
    assign rd_en    = (state == StRun) && !empty && (occ_next < 2'd2);
    assign m_valid  = (occ != 2'd0);
    assign m_data   = buf0;
    assign busy     = (state != StIdle) || (occ != 2'd0);
    assign wr_slot0 = (occ == 2'd0) || ((occ == 2'd1) && pop);

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state <= StIdle;
        end else begin
            unique case (state)
                StIdle:  if (drain_en) state <= StRun;
                StRun:   if (!drain_en) state <= StStop;
                StStop: begin
                    if (drain_en) begin
                        state <= StRun;
                    end else if (!inflight) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            buf0     <= '0;
            buf1     <= '0;
        end else begin
            occ      <= occ_next;
            inflight <= rd_en;
            if (pop) begin
                buf0 <= buf1;
            end
            // Returning word overrides the shift when it lands at the head.
            if (inflight) begin
                if (wr_slot0) begin
                    buf0 <= data_out;
                end else begin
                    buf1 <= data_out;
                end
            end
        end
    end

`ifdef FIFO_RD_DRAIN_COUNT_EN
    logic [Cnt_Width-1:0] count;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            count <= '0;
        end else if (pop) begin
            count <= count + 1'b1;
        end
    end

    assign rd_count = count;
`else
    assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Randomised bench for fifo_rd_drain against a queue-based model of the FIFO, skid buffer and stream.
module tb_fifo_rd_drain;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rd_rst;
    logic          drain_en;
    logic          empty;
    logic [7:0]    data_out;
    logic          rd_en;
    logic          m_valid;
    logic [7:0]    m_data;
    logic          m_ready;
    logic [CW-1:0] rd_count;
    logic          busy;

    fifo_rd_drain #(.Data_Width(8), .Cnt_Width(CW)) dut (
        .rd_clk   (clk),
        .rd_rst   (rd_rst),
        .drain_en (drain_en),
        .empty    (empty),
        .data_out (data_out),
        .rd_en    (rd_en),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .rd_count (rd_count),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Environment and model state
    logic [7:0] fifo[$];
    logic [7:0] mq[$];
    logic [7:0] log_q[$];
    bit         pend_v;
    logic [7:0] pend_d;
    int         st;         // 0 idle, 1 run, 2 stop
    int         delivered;
    bit         force_empty;
    bit         exp_rd_en, exp_pop, exp_valid;
    int         vectors, miscompares;
    int         stepno, first_rd, first_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pend_v    = 1'b0;
        st        = 0;
        delivered = 0;
    endtask

    function automatic logic [31:0] exp_count();
`ifdef FIFO_RD_DRAIN_COUNT_EN
        return delivered % (1 << CW);
`else
        return 0;
`endif
    endfunction

    task automatic step();
        logic [7:0] tmp;
        empty = force_empty || (fifo.size() == 0);
        @(negedge clk);
        exp_valid = (mq.size() != 0);
        exp_pop   = exp_valid && m_ready;
        exp_rd_en = !rd_rst && (st == 1) && !empty
                    && (int'(mq.size()) + int'(pend_v) - int'(exp_pop)) < 2;
        check("rd_en", {31'b0, rd_en}, {31'b0, exp_rd_en});
        check("m_valid", {31'b0, m_valid}, {31'b0, exp_valid});
        check("busy", {31'b0, busy}, {31'b0, (st != 0) || exp_valid});
        check("rd_count", {28'b0, rd_count}, exp_count());
        check("rd_en_while_empty", {31'b0, rd_en & empty}, 32'd0);
        if (exp_valid) check("m_data", {24'b0, m_data}, {24'b0, mq[0]});
        if (m_valid && m_ready) log_q.push_back(m_data);
        if (rd_en && first_rd < 0) first_rd = stepno;
        if (m_valid && first_val < 0) first_val = stepno;
        stepno++;
        @(posedge clk);
        #1;
        if (rd_rst) begin
            model_reset();
        end else begin
            if (exp_pop) begin
                tmp = mq.pop_front();
                delivered++;
            end
            if (pend_v) mq.push_back(pend_d);
            case (st)
                0: if (drain_en) st = 1;
                1: if (!drain_en) st = 2;
                default: if (drain_en) st = 1; else if (!pend_v) st = 0;
            endcase
            pend_v = exp_rd_en;
        end
        if (exp_rd_en) begin
            pend_d   = fifo.pop_front();
            data_out = pend_d;
        end else begin
            data_out = 8'($urandom);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        drain_en = 1'b0;
        m_ready  = 1'b1;
        force_empty = 1'b0;
        while ((st != 0 || mq.size() != 0 || pend_v) && n < 60) begin
            step();
            n++;
        end
        check(name, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rd_rst = 1'b1; drain_en = 1'b0; m_ready = 1'b0; data_out = 8'h00;
        force_empty = 1'b0; empty = 1'b1;
        model_reset();
        #1;
        check("rst_rd_en", {31'b0, rd_en}, 32'd0);
        check("rst_m_valid", {31'b0, m_valid}, 32'd0);
        check("rst_m_data", {24'b0, m_data}, 32'd0);
        check("rst_rd_count", {28'b0, rd_count}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        step();
        rd_rst = 1'b0;

        // Basic drain
        fifo = '{8'h11, 8'h22, 8'h33, 8'h44};
        drain_en = 1'b1; m_ready = 1'b1;
        log_q.delete(); stepno = 0; first_rd = -1; first_val = -1;
        repeat (8) step();
        check("basic_count", log_q.size(), 32'd4);
        if (log_q.size() == 4) begin
            check("basic_w0", {24'b0, log_q[0]}, 32'h11);
            check("basic_w1", {24'b0, log_q[1]}, 32'h22);
            check("basic_w2", {24'b0, log_q[2]}, 32'h33);
            check("basic_w3", {24'b0, log_q[3]}, 32'h44);
        end
        check("basic_latency", first_val - first_rd, 32'd2);
`ifdef FIFO_RD_DRAIN_COUNT_EN
        check("basic_rd_count", {28'b0, rd_count}, 32'd4);
`else
        check("basic_rd_count", {28'b0, rd_count}, 32'd0);
`endif
        wait_idle("basic_idle");

        // Backpressure
        for (int i = 0; i < 10; i++) fifo.push_back(8'hA0 + 8'(i));
        drain_en = 1'b1; m_ready = 1'b0;
        log_q.delete();
        repeat (5) step();
        check("bp_rd_en_low", {31'b0, rd_en}, 32'd0);
        check("bp_hold_valid", {31'b0, m_valid}, 32'd1);
        check("bp_hold_data", {24'b0, m_data}, 32'hA0);
        m_ready = 1'b1;
        repeat (20) step();
        check("bp_count", log_q.size(), 32'd10);
        for (int i = 0; i < 10 && i < log_q.size(); i++)
            check("bp_order", {24'b0, log_q[i]}, 32'hA0 + i);
        wait_idle("bp_idle");

        // Stop in the same cycle as a pop request
        for (int i = 0; i < 6; i++) fifo.push_back(8'h60 + 8'(i));
        drain_en = 1'b1; m_ready = 1'b1;
        repeat (3) step();
        drain_en = 1'b0;
        step();
        check("stop_rd_en_seen", {31'b0, exp_rd_en}, 32'd1);
        wait_idle("stop_idle");
        check("stop_left_in_fifo", fifo.size(), 32'd3);
        fifo.delete();

        // Reset with a full skid buffer
        for (int i = 0; i < 5; i++) fifo.push_back(8'h50 + 8'(i));
        drain_en = 1'b1; m_ready = 1'b0;
        repeat (5) step();
        check("rst_pre_full", mq.size(), 32'd2);
        rd_rst = 1'b1;
        #1;
        check("mrst_rd_en", {31'b0, rd_en}, 32'd0);
        check("mrst_m_valid", {31'b0, m_valid}, 32'd0);
        check("mrst_m_data", {24'b0, m_data}, 32'd0);
        check("mrst_rd_count", {28'b0, rd_count}, 32'd0);
        check("mrst_busy", {31'b0, busy}, 32'd0);
        model_reset();
        step();
        rd_rst = 1'b0;
        m_ready = 1'b1;
        repeat (10) step();
        wait_idle("mrst_idle");
        fifo.delete();

        // Counter wrap
        rd_rst = 1'b1;
        step();
        rd_rst = 1'b0;
        for (int i = 0; i < 20; i++) fifo.push_back(8'($urandom));
        drain_en = 1'b1; m_ready = 1'b1;
        for (int n = 0; n < 60 && delivered < 17; n++) step();
        check("wrap_pops", delivered, 32'd17);
`ifdef FIFO_RD_DRAIN_COUNT_EN
        check("wrap_rd_count", {28'b0, rd_count}, 32'd1);
`else
        check("wrap_rd_count", {28'b0, rd_count}, 32'd0);
`endif
        wait_idle("wrap_idle");
        fifo.delete();

        // Random traffic with toggling empty, backpressure and drain permission
        for (int n = 0; n < 1500; n++) begin
            if (fifo.size() < 3 && $urandom_range(1, 0) == 1) fifo.push_back(8'($urandom));
            drain_en    = ($urandom_range(7, 0) != 0);
            m_ready     = ($urandom_range(2, 0) != 0);
            force_empty = ($urandom_range(3, 0) == 0);
            step();
        end
        wait_idle("rand_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
